// File: rtl/bin2bcd_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_pkg
// Shared definitions for the sequential binary-to-BCD display block.
// Contents:
//   SEG_BLANK  - active-low pattern with every segment dark
//   SEG_DASH   - active-low pattern with only segment g lit ("-")
//   SEG_TABLE  - nibble to active-low segment glyph (bit0=a ... bit6=g)
//   state_t    - converter FSM states
// ---------------------------------------------------------------------------
package bin2bcd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Glyphs for 0-9; codes 10-15 never come out of the converter and are
    // shown dark so a corrupted nibble cannot masquerade as a digit.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b1111111,
        7'b1111111,
        7'b1111111,
        7'b1111111,
        7'b1111111,
        7'b1111111
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/bin2bcd_seq_display_seg7_digit_dec.sv
// ---------------------------------------------------------------------------
// seg7_digit_dec
// Combinational decoder for one seven-segment digit (active-low outputs).
// Ports:
//   nibble - BCD digit to display
//   blank  - force the digit dark
//   dash   - force a "-" glyph; takes priority over blank
//   seg    - active-low segments, bit0=a ... bit6=g
// ---------------------------------------------------------------------------
module seg7_digit_dec
    import bin2bcd_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    // Overflow dashes win over leading-zero blanking.
    always_comb begin
        if (dash) begin
            seg = SEG_DASH;
        end else if (blank) begin
            seg = SEG_BLANK;
        end else begin
            seg = SEG_TABLE[nibble];
        end
    end

endmodule

// File: rtl/bin2bcd_seq_display.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_display
// Sequential double-dabble converter (one input bit per clock) driving a bank
// of active-low seven-segment digits.
// Parameters: N_IN (input width), N_DIGITS (decimal digits), SEG_W (=7).
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset
//   start   - conversion request, only honoured while idle
//   bin_in  - unsigned value, captured when start is accepted
//   busy    - conversion in progress
//   done    - one-cycle pulse when a new result is registered
//   ovf     - last value did not fit in N_DIGITS decimal digits
//   bcd_out - registered BCD result, units digit in bits [3:0]
//   seg_out - active-low segments, digit k in bits [7k+6:7k]
// Build option: define LZB_EN to blank leading zero digits.
// ---------------------------------------------------------------------------
module bin2bcd_seq_display
    import bin2bcd_pkg::*;
#(
    parameter int N_IN     = 10,
    parameter int N_DIGITS = 4,
    parameter int SEG_W    = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N_IN-1:0]           bin_in,
    output logic                      busy,
    output logic                      done,
    output logic                      ovf,
    output logic [4*N_DIGITS-1:0]     bcd_out,
    output logic [SEG_W*N_DIGITS-1:0] seg_out
);

    localparam int CNT_W = $clog2(N_IN + 1);
    localparam int ACC_W = 4 * N_DIGITS;

    state_t             state_q, state_d;
    logic [N_IN-1:0]    shift_q, shift_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [ACC_W-1:0]   adj;
    logic [N_DIGITS-1:0] blank;

    // Next-state and datapath logic. Each SHIFT cycle applies the add-3
    // correction to every nibble, then shifts the accumulator and the
    // remaining input bits left as one long register. A 1 leaving the top
    // nibble means the value needs more digits than we have, so it is
    // remembered as overflow; the kept digits are then the value mod 10^N.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        adj = acc_q;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin_in;
                    acc_d     = '0;
                    cnt_d     = CNT_W'(N_IN);
                    ovf_acc_d = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                {acc_d, shift_d} = {adj[ACC_W-2:0], shift_q, 1'b0};
                ovf_acc_d        = ovf_acc_q | adj[ACC_W-1];
                cnt_d            = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                bcd_d   = acc_q;
                ovf_d   = ovf_acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // All state and outputs are registered; reset abandons any conversion
    // in flight without producing a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;
    assign bcd_out = bcd_q;

`ifdef LZB_EN
    logic seen_nz;

    // Scan from the most significant digit down; every digit above the
    // first non-zero one goes dark. The units digit is never blanked.
    always_comb begin
        seen_nz = 1'b0;
        blank   = '0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            if (bcd_q[4*k +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            blank[k] = ~seen_nz;
        end
    end
`else
    assign blank = '0;
`endif

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        seg7_digit_dec u_dec (
            .nibble (bcd_q[4*g +: 4]),
            .blank  (blank[g]),
            .dash   (ovf_q),
            .seg    (seg_out[SEG_W*g +: SEG_W])
        );
    end

endmodule

// File: tb/tb_bin2bcd_seq_display.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq_display
// Drives two converters: A with the default widths (10-bit in, 4 digits) and
// B with a 14-bit input into 4 digits, so overflow can be exercised. An
// arithmetic model of each is compared against the outputs every cycle, and
// a set of hand-worked values pins the model down.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        startA = 1'b0;
    logic        startB = 1'b0;
    logic [9:0]  binA = '0;
    logic [13:0] binB = '0;

    logic        busyA, doneA, ovfA;
    logic [15:0] bcdA;
    logic [27:0] segA;
    logic        busyB, doneB, ovfB;
    logic [15:0] bcdB;
    logic [27:0] segB;

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkEn     = 1'b0;

    always #5 clk = ~clk;

    bin2bcd_seq_display #(.N_IN(10), .N_DIGITS(4), .SEG_W(7)) dutA (
        .clk(clk), .rst(rst), .start(startA), .bin_in(binA),
        .busy(busyA), .done(doneA), .ovf(ovfA), .bcd_out(bcdA), .seg_out(segA)
    );

    bin2bcd_seq_display #(.N_IN(14), .N_DIGITS(4), .SEG_W(7)) dutB (
        .clk(clk), .rst(rst), .start(startB), .bin_in(binB),
        .busy(busyB), .done(doneB), .ovf(ovfB), .bcd_out(bcdB), .seg_out(segB)
    );

    // Standard active-low glyphs, bit0=a ... bit6=g
    function automatic logic [6:0] glyph(input int unsigned d);
        case (d)
            0: glyph = 7'h40;
            1: glyph = 7'h79;
            2: glyph = 7'h24;
            3: glyph = 7'h30;
            4: glyph = 7'h19;
            5: glyph = 7'h12;
            6: glyph = 7'h02;
            7: glyph = 7'h78;
            8: glyph = 7'h00;
            default: glyph = 7'h10;
        endcase
    endfunction

    function automatic logic [15:0] toBcd4(input int unsigned v);
        int unsigned r = v;
        logic [15:0] b = '0;
        for (int i = 0; i < 4; i++) begin
            b[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return b;
    endfunction

    // Display expected for a 4-digit value that already fits (value mod 10^4)
    function automatic logic [27:0] expSeg4(input int unsigned v, input logic o);
        logic [27:0] s = '0;
        int unsigned p = 1;
        for (int k = 0; k < 4; k++) begin
            if (o) begin
                s[7*k +: 7] = 7'b0111111;
            end else begin
                s[7*k +: 7] = glyph((v / p) % 10);
`ifdef LZB_EN
                if (k > 0 && v < p) s[7*k +: 7] = 7'b1111111;
`endif
            end
            p = p * 10;
        end
        return s;
    endfunction

    // Reference models: a conversion accepted at one edge reports its result
    // N_IN+1 edges later; the result is the value mod 10^4 plus overflow.
    bit          mBusyA = 0, mDoneA = 0, mOvfA = 0;
    int          mRemA = 0;
    int unsigned mValA = 0, mModA = 0;
    bit          mBusyB = 0, mDoneB = 0, mOvfB = 0;
    int          mRemB = 0;
    int unsigned mValB = 0, mModB = 0;

    always @(posedge clk) begin
        if (rst) begin
            mBusyA <= 0; mDoneA <= 0; mOvfA <= 0; mModA <= 0; mRemA <= 0;
        end else begin
            mDoneA <= 0;
            if (!mBusyA) begin
                if (startA) begin
                    mBusyA <= 1; mValA <= 32'(binA); mRemA <= 11;
                end
            end else if (mRemA == 1) begin
                mBusyA <= 0; mDoneA <= 1;
                mModA  <= mValA % 10000; mOvfA <= (mValA >= 10000);
            end else begin
                mRemA <= mRemA - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            mBusyB <= 0; mDoneB <= 0; mOvfB <= 0; mModB <= 0; mRemB <= 0;
        end else begin
            mDoneB <= 0;
            if (!mBusyB) begin
                if (startB) begin
                    mBusyB <= 1; mValB <= 32'(binB); mRemB <= 15;
                end
            end else if (mRemB == 1) begin
                mBusyB <= 0; mDoneB <= 1;
                mModB  <= mValB % 10000; mOvfB <= (mValB >= 10000);
            end else begin
                mRemB <= mRemB - 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the models
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("busyA", 32'(busyA), 32'(mBusyA));
            checkOutput("doneA", 32'(doneA), 32'(mDoneA));
            checkOutput("ovfA",  32'(ovfA),  32'(mOvfA));
            checkOutput("bcdA",  32'(bcdA),  32'(toBcd4(mModA)));
            checkOutput("segA",  32'(segA),  32'(expSeg4(mModA, mOvfA)));
            checkOutput("busyB", 32'(busyB), 32'(mBusyB));
            checkOutput("doneB", 32'(doneB), 32'(mDoneB));
            checkOutput("ovfB",  32'(ovfB),  32'(mOvfB));
            checkOutput("bcdB",  32'(bcdB),  32'(toBcd4(mModB)));
            checkOutput("segB",  32'(segB),  32'(expSeg4(mModB, mOvfB)));
        end
    end

    // Called just after a clock edge; start is seen by the next edge.
    task automatic applyStimulus(input bit goA, input bit goB, input logic [9:0] a, input logic [13:0] b);
        startA = goA; binA = a;
        startB = goB; binB = b;
        @(posedge clk); #1;
        startA = 1'b0;
        startB = 1'b0;
    endtask

    // Edges from acceptance until done is seen; -1 if the budget runs out
    task automatic waitDone(input bit selB, input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if ((selB ? doneB : doneA) === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    logic [9:0]  dirA [5] = '{10'd0, 10'd9, 10'd100, 10'd999, 10'd1023};
    logic [13:0] dirB [5] = '{14'd9999, 14'd10000, 14'd16383, 14'd0, 14'd10};

    initial begin
        int lat;
        int nDone, d1, d2;
        logic [27:0] zeroSeg;

        rst = 1'b1;
        @(posedge clk); #1;
        checkEn = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

`ifdef LZB_EN
        zeroSeg = {7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
        zeroSeg = {7'h40, 7'h40, 7'h40, 7'h40};
`endif
        checkOutput("rst_busy", 32'(busyA), 32'd0);
        checkOutput("rst_done", 32'(doneA), 32'd0);
        checkOutput("rst_ovf",  32'(ovfA),  32'd0);
        checkOutput("rst_bcd",  32'(bcdA),  32'd0);
        checkOutput("rst_seg",  32'(segA),  32'(zeroSeg));

        // 1023 on the default build: result after 11 edges
        applyStimulus(1'b1, 1'b0, 10'd1023, 14'd0);
        checkOutput("busy_after_start", 32'(busyA), 32'd1);
        waitDone(1'b0, 20, lat);
        checkOutput("lat_1023", 32'(lat), 32'd11);
        checkOutput("bcd_1023", 32'(bcdA), 32'h1023);
        checkOutput("ovf_1023", 32'(ovfA), 32'd0);
        checkOutput("seg_1023", 32'(segA), 32'({7'h79, 7'h40, 7'h24, 7'h30}));
        @(posedge clk); #1;
        checkOutput("done_one_cycle", 32'(doneA), 32'd0);

        // Zero
        applyStimulus(1'b1, 1'b0, 10'd0, 14'd0);
        waitDone(1'b0, 20, lat);
        checkOutput("bcd_0", 32'(bcdA), 32'h0000);
        checkOutput("seg_0", 32'(segA), 32'(zeroSeg));

        // 12345 into four digits overflows
        applyStimulus(1'b0, 1'b1, 10'd0, 14'd12345);
        waitDone(1'b1, 25, lat);
        checkOutput("lat_B", 32'(lat), 32'd15);
        checkOutput("ovf_12345", 32'(ovfB), 32'd1);
        checkOutput("bcd_12345", 32'(bcdB), 32'h2345);
        checkOutput("seg_12345", 32'(segB), 32'({4{7'b0111111}}));

        // Starts at edges 0, 3 and 12: edge 3 falls mid-conversion and is
        // dropped; edge 12 is the first idle edge after the done at edge 11.
        nDone = 0; d1 = -1; d2 = -1;
        for (int e = 0; e <= 30; e++) begin
            startA = (e == 0 || e == 3 || e == 12);
            binA   = (e == 0) ? 10'd111 : (e == 3) ? 10'd222 : (e == 12) ? 10'd333 : 10'd777;
            @(posedge clk); #1;
            if (doneA === 1'b1) begin
                nDone++;
                if (nDone == 1) d1 = e; else d2 = e;
            end
        end
        startA = 1'b0;
        checkOutput("ignore_count", 32'(nDone), 32'd2);
        checkOutput("ignore_d1",    32'(d1),    32'd11);
        checkOutput("ignore_d2",    32'(d2),    32'd23);
        checkOutput("ignore_bcd",   32'(bcdA),  32'h0333);

        // Reset at edge 5 of a conversion
        applyStimulus(1'b1, 1'b0, 10'd999, 14'd0);
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midrst_busy", 32'(busyA), 32'd0);
        checkOutput("midrst_bcd",  32'(bcdA),  32'd0);
        nDone = 0;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk); #1;
            if (doneA === 1'b1) nDone++;
        end
        checkOutput("midrst_nodone", 32'(nDone), 32'd0);
        applyStimulus(1'b1, 1'b0, 10'd456, 14'd0);
        waitDone(1'b0, 20, lat);
        checkOutput("after_rst_lat", 32'(lat), 32'd11);
        checkOutput("after_rst_bcd", 32'(bcdA), 32'h0456);

        // Boundary values then random values on both widths
        for (int i = 0; i < 14; i++) begin
            logic [9:0]  a;
            logic [13:0] b;
            a = (i < 5) ? dirA[i] : 10'($urandom_range(1023));
            b = (i < 5) ? dirB[i] : 14'($urandom_range(16383));
            applyStimulus(1'b1, 1'b1, a, b);
            waitDone(1'b1, 25, lat);
            checkOutput("sweep_lat", 32'(lat), 32'd15);
        end

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
